// File: rtl/logic_unit_serial_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_serial_pkg
// Shared types and defaults for the bit-serial logic unit.
//   op_t    : bitwise operation select (AND, OR, XOR, NAND)
//   state_t : sequencer states (IDLE, BUSY, DONE)
//   WIDTH_DEFAULT : default operand/result width
// Optional feature macro used by the top level: LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
// -----------------------------------------------------------------------------
package logic_unit_serial_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : logic_unit_serial_pkg

// File: rtl/logic_unit_serial_bit_cell.sv
// -----------------------------------------------------------------------------
// logic_bit_cell
// Purely combinational 1-bit logic cell shared by every bit position of the
// serial unit.
// Ports:
//   a  : operand A bit
//   b  : operand B bit
//   op : operation select (op_t)
//   y  : result bit
// -----------------------------------------------------------------------------
module logic_bit_cell
   import logic_unit_serial_pkg::*;
(
   input  logic a,
   input  logic b,
   input  op_t  op,
   output logic y
);

   // Select the bitwise function for this bit
   always_comb begin
      y = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = 1'b0;
      endcase
   end

endmodule : logic_bit_cell

// File: rtl/logic_unit_serial.sv
// -----------------------------------------------------------------------------
// logic_unit_serial
// Bit-serial bitwise logic unit. Operands are captured on an input
// valid/ready handshake, processed LSB first through a single 1-bit cell
// (one bit per clock), and the full word is presented on an output
// valid/ready handshake.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   in_valid  : operands/op presented
//   in_ready  : block can accept operands (registered)
//   a, b      : WIDTH-bit operands
//   op        : operation select (op_t)
//   out_valid : result available (registered)
//   out_ready : consumer accepts result
//   result    : computed word (registered, changes only on entry to DONE)
//   zero      : result==0 flag, present only with LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
//
// Configuration macro: LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
//   When defined, adds the zero output, built serially by OR-accumulating the
//   produced bits and registered together with result.
// -----------------------------------------------------------------------------
module logic_unit_serial
   import logic_unit_serial_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int unsigned       CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q;
   logic [WIDTH-1:0]  sa_q;
   logic [WIDTH-1:0]  sb_q;
   op_t               sop_q;
   logic [WIDTH-1:0]  acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WIDTH-1:0]  result_q;
   logic              in_ready_q;
   logic              out_valid_q;

   logic              bit_s;
   logic [WIDTH-1:0]  sa_d;
   logic [WIDTH-1:0]  sb_d;
   logic [WIDTH-1:0]  acc_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              last_s;

`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
   logic              zacc_q;
   logic              zacc_d;
   logic              zero_q;
`endif

   // Single shared logic cell, fed from the LSBs of the shift registers
   logic_bit_cell u_cell (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .op (sop_q),
      .y  (bit_s)
   );

   // Next-state datapath for one BUSY step: shift operands, insert new bit at
   // the top of the accumulator so the first (LSB) bit ends in acc[0]
   always_comb begin
      sa_d   = sa_q >> 1;
      sb_d   = sb_q >> 1;
      acc_d  = {bit_s, acc_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CNT_ONE;
      last_s = (cnt_q == LAST_BIT);
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
      zacc_d = zacc_q | bit_s;
`endif
   end

   // Sequencer with registered handshake outputs, result and operand capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sa_q        <= '0;
         sb_q        <= '0;
         sop_q       <= OP_AND;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
         zacc_q      <= 1'b0;
         zero_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sa_q       <= a;
                  sb_q       <= b;
                  sop_q      <= op;
                  acc_q      <= '0;
                  cnt_q      <= '0;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
                  zacc_q     <= 1'b0;
`endif
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end else begin
                  state_q    <= IDLE;
               end
            end
            BUSY: begin
               sa_q  <= sa_d;
               sb_q  <= sb_d;
               acc_q <= acc_d;
               cnt_q <= cnt_d;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
               zacc_q <= zacc_d;
`endif
               // The WIDTH-th bit is being produced on this edge
               if (last_s) begin
                  result_q    <= acc_d;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
                  zero_q      <= ~zacc_d;
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q     <= BUSY;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= DONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
   assign zero      = zero_q;
`endif

endmodule : logic_unit_serial

// File: tb/tb_logic_unit_serial.sv
module tb_logic_unit_serial;
   import logic_unit_serial_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   op_t          op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
   logic         zero;
`endif

   logic_unit_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      int           t_acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples shortly after the falling edge, pops on output handshake
   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst) begin
         if (out_valid && !ov_prev) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               check("latency", 32'(cyc - sb_q[0].t_acc), 32'(W));
            end
         end
         if (out_valid && out_ready && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("result", 32'(result), 32'(e.res));
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
            check("zero", 32'(zero), 32'(e.res == '0));
`endif
         end
      end
      ov_prev = out_valid;
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input op_t vop,
                       input logic [W-1:0] exp, input bit push, input bit scramble);
      wait_ready();
      a        = va;
      b        = vb;
      op       = vop;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) sb_q.push_back('{res: exp, t_acc: cyc});
      check("in_ready_drop", 32'(in_ready), 32'd0);
      if (scramble) begin
         a  = ~va;
         b  = ~vb;
         op = OP_OR;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      op        = OP_AND;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
`ifdef LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
      check("rst_zero", 32'(zero), 32'd0);
`endif
      rst = 1'b0;

      // AND with latency and return-to-idle
      send(8'hF0, 8'h3C, OP_AND, 8'h30, 1'b1, 1'b0);
      wait_valid();
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back remaining ops
      send(8'hF0, 8'h3C, OP_OR,   8'hFC, 1'b1, 1'b0);
      send(8'hF0, 8'h3C, OP_XOR,  8'hCC, 1'b1, 1'b0);
      send(8'hF0, 8'h3C, OP_NAND, 8'hCF, 1'b1, 1'b0);

      // Operands changed right after accept
      send(8'h12, 8'h34, OP_AND, 8'h10, 1'b1, 1'b1);

      // Backpressure for 5 cycles in DONE, with in_valid asserted meanwhile
      wait_ready();
      out_ready = 1'b0;
      send(8'h5A, 8'h0F, OP_XOR, 8'h55, 1'b1, 1'b0);
      wait_valid();
      a        = 8'hFF;
      b        = 8'hFF;
      op       = OP_AND;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", 32'(result), 32'h55);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      check("bp_done_out_valid", 32'(out_valid), 32'd0);
      check("bp_done_in_ready", 32'(in_ready), 32'd1);
      check("bp_result_hold", 32'(result), 32'h55);

      // Reset after 3 BUSY cycles aborts the operation
      send(8'hC3, 8'h81, OP_AND, 8'h81, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      send(8'hAA, 8'h55, OP_OR, 8'hFF, 1'b1, 1'b0);

      // Zero-flag vectors (results also checked without the flag)
      send(8'hAA, 8'h55, OP_AND, 8'h00, 1'b1, 1'b0);
      send(8'h01, 8'h01, OP_AND, 8'h01, 1'b1, 1'b0);

      wait_ready();
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_logic_unit_serial

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
Bit-serial counterpart to the team's parallel bitwise gate hierarchy. Accepts two WIDTH-bit operands and an opcode through a valid/ready handshake. Computes the bitwise result one bit per clock using a single 1-bit logic cell, then presents the full word on a valid/ready output handshake. Used where area matters more than latency, for example in the TGA datapath's slow logic path.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  operation select (package type op_t)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  computed word

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, in_ready=1, out_valid=0, result=0. Internal shift registers and counter are also 0.
- op encoding: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND (bitwise).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE: on an edge with in_valid=1, latch a, b and op into sa, sb and sop; clear the bit counter; go to BUSY. If in_valid=0, stay in IDLE.
- BUSY, every edge:
  - bit = cell(sa[0], sb[0], sop).
  - Shift right: sa>>=1, sb>>=1, and acc={bit, acc[WIDTH-1:1]} (LSB computed first, ends in acc[0]).
  - Increment the counter.
  - On the edge that processes the WIDTH-th bit: load result<=final acc word and go to DONE.
- Latency: accept on edge T; out_valid=1 from edge T+WIDTH (8 cycles for the default).
- DONE: out_valid, result and op stay stable until out_ready=1. On that edge go to IDLE; result keeps its value and out_valid drops.
- No overlap: a new accept can only happen one cycle after the output handshake. in_valid is ignored in BUSY and DONE. out_ready is ignored outside DONE.
- result changes only on the transition into DONE. It holds the last word indefinitely otherwise.
- Reset mid-operation (BUSY or DONE): the operation is aborted and the result is discarded. The block returns to reset values; no partial output appears.
- The operands are captured at accept. Changing a, b or op afterwards has no effect on the operation in flight.

Optional Feature:
LOGIC_UNIT_SERIAL_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit).
  - Reset value 0.
  - Computed serially by OR-accumulating each produced bit during BUSY.
  - Registered alongside result on entry to DONE; zero=1 iff result==0.
  - Held with the same stability rules as result.
- Undefined: port zero and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_serial_pkg:
  - op_t enum (OP_AND, OP_OR, OP_XOR, OP_NAND).
  - state_t enum (IDLE, BUSY, DONE).
  - Default WIDTH localparam.
- Counter width is $clog2(WIDTH+1), derived in the module.
- One sub-module, logic_bit_cell: purely combinational 1-bit cell with inputs a, b, op and output y, instantiated once.

Test Plan:
- a=8'hF0, b=8'h3C, op=AND, in_valid pulse, out_ready=1:
  - in_ready drops the next cycle.
  - out_valid rises exactly 8 cycles after the accept edge with result=8'h30.
  - Returns to IDLE one cycle later.
- Same operands with OR, XOR, NAND back-to-back:
  - results 8'hFC, 8'hCC, 8'hCF in turn.
  - Each accept occurs only when in_ready=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE:
  - out_valid=1 and result stable throughout; in_ready=0; in_valid ignored.
  - Completes on the cycle out_ready goes to 1.
- Operand change after accept: change a and b on the cycle after the accept edge → result still reflects the captured values.
- Reset mid-operation: assert rst after 3 BUSY cycles:
  - outputs go immediately to out_valid=0, result=0, in_ready=1.
  - A following op (8'hAA OR 8'h55) yields 8'hFF.
- With LOGIC_UNIT_SERIAL_ZERO_FLAG_EN defined:
  - 8'hAA AND 8'h55 gives result=8'h00 and zero=1.
  - 8'h01 AND 8'h01 gives result=8'h01 and zero=0.
